// File: rtl/gpio_debounce_pkg.sv
// Shared constants for the GPIO debouncer: the board clock, the debounce time and
// the per-bit counter width helper.
package gpio_pkg;

    localparam int unsigned GPIO_WIDTH              = 32'd8;
    localparam int unsigned CLK_HZ                  = 32'd50000000;
    localparam int unsigned DEBOUNCE_MS             = 32'd5;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 32'd1000) * DEBOUNCE_MS;

    // Counter must hold 0..DEBOUNCE_CYCLES
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 32'd1);
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One debounced GPIO bit: two-flop synchronizer, stability counter, accepted level
// and, when GPIO_DEBOUNCE_EDGE_EN is defined, registered rise/fall pulses.
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic gpio_i,
    output logic gpio_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned        CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic             sync1_q;
    logic             sync2_q;
    logic             state_q;
    logic             state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive cycles the synchronized input differs from the accepted level;
    // a single agreeing cycle throws the count away.
    always_comb begin
        state_d = state_q;
        cnt_d   = {CNT_W{1'b0}};
        if (sync2_q != state_q) begin
            if (cnt_q == CNT_MAX) begin
                state_d = sync2_q;
                cnt_d   = {CNT_W{1'b0}};
            end else begin
                cnt_d   = cnt_q + CNT_W'(32'd1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Synchronizer, counter and accepted-level registers
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gpio_o = state_q;

`ifdef GPIO_DEBOUNCE_EDGE_EN
    logic rise_q;
    logic rise_d;
    logic fall_q;
    logic fall_d;

    // Pulses line up with the first cycle the new level is visible on gpio_o
    always_comb begin
        rise_d = state_d & ~state_q;
        fall_d = ~state_d & state_q;
    end

    // Edge pulse registers
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/gpio_debounce.sv
// WIDTH-bit GPIO input conditioner built from independent per-bit debouncers.
// Define GPIO_DEBOUNCE_EDGE_EN to implement rise_o/fall_o/changed_o; otherwise they read 0.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH           = GPIO_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             changed_o
);

    for (genvar n = 0; n < WIDTH; n++) begin : g_bit
        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk_i  (clk_i),
            .reset_i(reset_i),
            .gpio_i (gpio_i[n]),
            .gpio_o (gpio_o[n]),
            .rise_o (rise_o[n]),
            .fall_o (fall_o[n])
        );
    end

    assign changed_o = |(rise_o | fall_o);

endmodule

// File: tb/tb_gpio_debounce.sv
// Scoreboard bench for gpio_debounce with DEBOUNCE_CYCLES=4 (plus a DEBOUNCE_CYCLES=1 instance).
module tb_gpio_debounce;

    localparam int W = 8;
`ifdef GPIO_DEBOUNCE_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] g;
        logic [W-1:0] r;
        logic [W-1:0] f;
        logic         c;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [W-1:0] gpio_i;
    logic [W-1:0] gpio_o, rise_o, fall_o;
    logic         changed_o;
    logic [W-1:0] gpio1_o, rise1_o, fall1_o;
    logic         changed1_o;

    exp_t sb[$];
    exp_t e;
    exp_t obs;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    gpio_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .gpio_i(gpio_i),
        .gpio_o(gpio_o), .rise_o(rise_o), .fall_o(fall_o), .changed_o(changed_o)
    );

    gpio_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .gpio_i(gpio_i),
        .gpio_o(gpio1_o), .rise_o(rise1_o), .fall_o(fall1_o), .changed_o(changed1_o)
    );

    function automatic exp_t mk(input logic [W-1:0] g, input logic [W-1:0] r, input logic [W-1:0] f);
        exp_t x;
        x.g = g;
        x.r = EDGE ? r : 8'h00;
        x.f = EDGE ? f : 8'h00;
        x.c = EDGE ? |(r | f) : 1'b0;
        return x;
    endfunction

    task automatic do_reset(input logic [W-1:0] level);
        reset_i = 1'b0;
        gpio_i  = level;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b1;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        gpio_i  = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk(8'h00, 8'h00, 8'h00));
            @(posedge clk); #1;
            obs = {gpio_o, rise_o, fall_o, changed_o};
            e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL reset_hold cycle %0d: got %h expected %h", k, obs, e); end
        end
        reset_i = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            sb.push_back(mk((k >= 6) ? 8'hFF : 8'h00, (k == 6) ? 8'hFF : 8'h00, 8'h00));
            @(posedge clk); #1;
            obs = {gpio_o, rise_o, fall_o, changed_o};
            e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL reset_release edge +%0d: got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_single_rise();
        do_reset(8'h00);
        gpio_i = 8'h01;
        for (int k = 0; k < 9; k++) begin
            sb.push_back(mk((k >= 5) ? 8'h01 : 8'h00, (k == 5) ? 8'h01 : 8'h00, 8'h00));
            @(posedge clk); #1;
            obs = {gpio_o, rise_o, fall_o, changed_o};
            e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL single_rise edge %0d: got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        pat = 8'b1111_0111;
        do_reset(8'h00);
        for (int k = 0; k < 13; k++) begin
            gpio_i = (k < 8 && !pat[k]) ? 8'h00 : 8'h08;
            sb.push_back(mk((k >= 9) ? 8'h08 : 8'h00, (k == 9) ? 8'h08 : 8'h00, 8'h00));
            @(posedge clk); #1;
            obs = {gpio_o, rise_o, fall_o, changed_o};
            e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL bounce edge %0d: got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_glitch();
        do_reset(8'h00);
        for (int k = 0; k < 10; k++) begin
            gpio_i = (k < 3) ? 8'h80 : 8'h00;
            sb.push_back(mk(8'h00, 8'h00, 8'h00));
            @(posedge clk); #1;
            obs = {gpio_o, rise_o, fall_o, changed_o};
            e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL glitch edge %0d: got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(8'h00);
        gpio_i = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            sb.push_back(mk((k >= 5) ? 8'hA5 : 8'h00, (k == 5) ? 8'hA5 : 8'h00, 8'h00));
            @(posedge clk); #1;
            obs = {gpio_o, rise_o, fall_o, changed_o};
            e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL multi_rise edge %0d: got %h expected %h", k, obs, e); end
        end
        gpio_i = 8'h00;
        for (int k = 0; k < 8; k++) begin
            sb.push_back(mk((k >= 5) ? 8'h00 : 8'hA5, 8'h00, (k == 5) ? 8'hA5 : 8'h00));
            @(posedge clk); #1;
            obs = {gpio_o, rise_o, fall_o, changed_o};
            e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL multi_fall edge %0d: got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_reset_midcount();
        do_reset(8'h00);
        gpio_i = 8'h04;
        repeat (4) @(posedge clk);
        #1 reset_i = 1'b0;
        sb.push_back(mk(8'h00, 8'h00, 8'h00));
        @(posedge clk); #1;
        obs = {gpio_o, rise_o, fall_o, changed_o};
        e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL midcount_reset: got %h expected %h", obs, e); end
        reset_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            sb.push_back(mk((k >= 6) ? 8'h04 : 8'h00, (k == 6) ? 8'h04 : 8'h00, 8'h00));
            @(posedge clk); #1;
            obs = {gpio_o, rise_o, fall_o, changed_o};
            e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL midcount_release edge +%0d: got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_one_cycle();
        do_reset(8'h00);
        for (int k = 0; k < 8; k++) begin
            gpio_i = (k < 4) ? 8'h02 : 8'h00;
            sb.push_back(mk((k >= 2 && k < 6) ? 8'h02 : 8'h00,
                            (k == 2) ? 8'h02 : 8'h00, (k == 6) ? 8'h02 : 8'h00));
            @(posedge clk); #1;
            obs = {gpio1_o, rise1_o, fall1_o, changed1_o};
            e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL dc1 edge %0d: got %h expected %h", k, obs, e); end
        end
    endtask

    initial begin
        reset_i = 1'b0;
        gpio_i  = 8'h00;
        @(posedge clk); #1;
        test_reset();
        test_single_rise();
        test_bounce();
        test_glitch();
        test_back_to_back();
        test_reset_midcount();
        test_one_cycle();
        n_checks++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
